// File: rtl/spm_serial_mult.sv
// Serial-parallel carry-save multiplier: parallel x times serial y (LSB first),
// with signed/unsigned mode, start/busy/done handshake and a registered parallel product.
module spm_serial_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(2*WIDTH)+1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               p_valid,
  output logic               p_serial,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2*WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PW-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_sh_q, y_sh_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic              signed_q, signed_d;
  logic [PW-2:0]     sh_q, sh_d;
  logic [PW-1:0]     p_q, p_d;
  logic              busy_q, busy_d;
  logic              p_serial_q, p_serial_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  cell_s;
  logic [WIDTH-1:0]  cell_c;
  logic              top_pp_s;
  logic              last_s;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // One carry-save step T' = ybit*X + floor(T/2); the top cell serially negates
  // its partial-product stream in signed mode (its carry flop is the "seen a one" flag).
  always_comb begin
    cell_s   = '0;
    cell_c   = '0;
    top_pp_s = x_q[WIDTH-1] & y_sh_q[0];
    for (int j = 0; j < WIDTH-1; j++) begin
      cell_s[j] = fa_sum(x_q[j] & y_sh_q[0], s_q[j+1], c_q[j]);
      cell_c[j] = fa_carry(x_q[j] & y_sh_q[0], s_q[j+1], c_q[j]);
    end
    cell_s[WIDTH-1] = top_pp_s ^ c_q[WIDTH-1];
    if (signed_q) begin
      cell_c[WIDTH-1] = c_q[WIDTH-1] | top_pp_s;
    end else begin
      cell_c[WIDTH-1] = c_q[WIDTH-1] & top_pp_s;
    end
  end

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    last_s     = (cnt_q == LAST_CNT);
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_sh_d     = y_sh_q;
    s_d        = s_q;
    c_d        = c_q;
    signed_d   = signed_q;
    sh_d       = sh_q;
    p_d        = p_q;
    busy_d     = busy_q;
    p_serial_d = p_serial_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Accept folds in the first step (ybit = y[0]) on top of cleared cells,
          // so product bit 0 is on p_serial in the very first RUN cycle.
          state_d    = ST_RUN;
          cnt_d      = '0;
          x_d        = x;
          signed_d   = signed_mode;
          y_sh_d     = {signed_mode & y[WIDTH-1], y[WIDTH-1:1]};
          s_d        = x & {WIDTH{y[0]}};
          c_d        = {signed_mode & x[WIDTH-1] & y[0], {(WIDTH-1){1'b0}}};
          sh_d       = '0;
          busy_d     = 1'b1;
          p_serial_d = x[0] & y[0];
        end else begin
          state_d    = ST_IDLE;
          p_serial_d = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        y_sh_d = {y_sh_q[WIDTH-1], y_sh_q[WIDTH-1:1]};
        s_d    = cell_s;
        c_d    = cell_c;
        sh_d   = {s_q[0], sh_q[PW-2:1]};
        if (last_s) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          p_serial_d = 1'b0;
          p_d        = {s_q[0], sh_q};
        end else begin
          p_serial_d = cell_s[0];
        end
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        p_serial_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_sh_q     <= '0;
      s_q        <= '0;
      c_q        <= '0;
      signed_q   <= 1'b0;
      sh_q       <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      p_serial_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_sh_q     <= y_sh_d;
      s_q        <= s_d;
      c_q        <= c_d;
      signed_q   <= signed_d;
      sh_q       <= sh_d;
      p_q        <= p_d;
      busy_q     <= busy_d;
      p_serial_q <= p_serial_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign p_valid  = busy_q;
  assign p_serial = p_serial_q;
  assign done     = done_q;
  assign p        = p_q;

endmodule

// File: doc/spm_serial_mult.md
Name: spm_serial_mult

Overview:
- Parametrised successor of the fixed-width serial-parallel multiplier (spm) carry-save datapath.
- Multiplies a parallel operand x by operand y. y is loaded in parallel and fed serially, LSB first, through a chain of WIDTH carry-save adder cells; each cell holds its own sum and carry registers.
- Generalises the fixed design in three ways: WIDTH parameter, signed/unsigned mode, and a start/busy/done handshake.
- Output: serial product stream plus a registered parallel product. Sits between operand registers and the accumulator datapath.

Parameters:
- WIDTH, 32, operand width in bits; legal range >= 2.
- CNT_W, $clog2(2*WIDTH)+1, cycle-counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when idle or in DONE.
- signed_mode  input  1  1 = two's-complement operands; captured at accept.
- x  input  WIDTH  parallel multiplicand; captured at accept.
- y  input  WIDTH  multiplier; captured at accept, then shifted out serially LSB first.
- busy  output  1  high while RUN.
- p_valid  output  1  high when p_serial carries a product bit.
- p_serial  output  1  product bit, LSB first.
- done  output  1  one-cycle pulse when p is valid.
- p  output  2*WIDTH  parallel product; held until the next accept.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE; busy=0, p_valid=0, p_serial=0, done=0, p=0; all CSA sum/carry registers=0; counter=0.
- States:
  - IDLE: start=1 -> RUN; capture x, y, signed_mode; clear CSA registers.
  - RUN: counter 0..2*WIDTH-1; at 2*WIDTH-1 -> DONE.
  - DONE: lasts one cycle. start=1 -> RUN (back-to-back accept, same capture as IDLE); else -> IDLE.
- Accept at edge k gives this timing:
  - busy=1 and p_valid=1 during cycles k+1..k+2W.
  - p_serial in cycle k+1+i equals product bit i.
  - done=1 in cycle k+2W+1, with p already holding the full product.
- Serial y stream:
  - Bit i for i<WIDTH is y[i].
  - For i>=WIDTH it is y[WIDTH-1] when signed_mode=1, else 0.
- Cell j computes x[j]&ybit + sum from cell j+1 + its own carry.
- Signed mode: cell WIDTH-1 subtracts its partial product (two's-complement top cell).
- Result: p = (x*y) mod 2^(2W), with operands interpreted per captured signed_mode.
- p is assembled by shifting p_serial into a 2W shift register. It is transferred to output p on the final RUN cycle, so p changes only on that edge or on rst.
- start while RUN: ignored; no effect on operands or timing.
- x/y/signed_mode changes during RUN: no effect, since captured values are used.
- rst during RUN or DONE: returns to IDLE next edge with all reset values (p=0). The partial product is discarded and no done is issued.
- rst and start in the same cycle: rst wins; the start is dropped.
- Counter wrap: never wraps; it is cleared on accept.
- WIDTH=2 must work: RUN lasts 4 cycles.

Test Plan:
- WIDTH=8, unsigned, x=0xFF, y=0xFF, start one cycle -> busy 16 cycles; p_serial LSB-first = 0xFE01; done pulse; p=0xFE01.
- WIDTH=8, signed, x=0xFF (-1), y=0xFF (-1) -> p=0x0001; signed x=0x80 (-128), y=0x7F (127) -> p=0xC080; unsigned 0x80*0x7F -> p=0x3F80.
- Accept x=3, y=5 (unsigned), pulse start again at RUN cycle 4 with x=7, y=7 -> ignored; p=0x000F after exactly 16 busy cycles.
- Hold start=1 continuously with x=2, y=3 -> done pulses every 17 cycles; p=0x0006 each time; busy drops only during DONE cycles.
- rst asserted at RUN cycle 5 of x=0xAA, y=0x55 -> next cycle busy=0, p_valid=0, p=0, no done. A new start then yields p=0x3872 correctly (no residue in CSA registers).
- WIDTH=2, signed, x=2'b10 (-2), y=2'b11 (-1) -> busy 4 cycles; p=4'b0010.
